// File: rtl/vector_assembler_pkg.sv
// -----------------------------------------------------------------------------
// vector_assembler_pkg
// Shared constants and types for the byte-to-vector assembler.
//   VEC_W          : width of the assembled vector (255 bits)
//   BYTES_PER_VEC  : bytes per full frame (32)
//   LEN_W          : width of the byte-count field (6, holds 0..32)
//   LAST_IDX       : byte index that completes a full frame
//   state_t        : FILL (collecting bytes) / HOLD (presenting the vector)
// -----------------------------------------------------------------------------
package vector_assembler_pkg;

    localparam int VEC_W         = 255;
    localparam int BYTES_PER_VEC = 32;
    localparam int LEN_W         = 6;

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(BYTES_PER_VEC - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : vector_assembler_pkg

// File: rtl/vector_assembler.sv
// -----------------------------------------------------------------------------
// vector_assembler
// Packs a stream of bytes into a 255-bit vector for the population-count
// stage. Byte k lands in vec[8k+7:8k]; the top bit of byte 31 has no home and
// is dropped. A frame ends after 32 bytes or on an accepted in_last, after
// which the vector is held until the consumer takes it with vec_ready.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_data    in   8    incoming byte
//   in_valid   in   1    in_data / in_last valid
//   in_last    in   1    this byte ends the frame early (rest zero-filled)
//   in_ready   out  1    byte accepted this cycle when in_valid is high
//   sync_clr   in   1    synchronous discard of partial or held frame
//   vec        out  255  assembled vector (drives popcount input directly)
//   vec_valid  out  1    vec complete and stable
//   vec_ready  in   1    consumer takes vec this cycle
//   vec_len    out  6    bytes received in the current/held frame
//   frame_cnt  out  8    frames delivered, modulo 256
// -----------------------------------------------------------------------------
module vector_assembler
    import vector_assembler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             sync_clr,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [LEN_W-1:0] vec_len,
    output logic [7:0]       frame_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [LEN_W-1:0]   r_vec_len;
    logic [7:0]         r_frame_cnt;

    logic               w_accept;
    logic               w_final;
    logic               w_release;
    logic [7:0]         w_bit_base;
    // One spare bit on top so byte 31 can be written as a whole byte; its
    // MSB falls into the spare bit and is discarded on truncation.
    logic [VEC_W:0]     w_vec_ins;

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM next-state and handshake decode ----
    always_comb begin
        w_accept    = in_valid && (r_state == FILL);
        w_final     = w_accept && (in_last || (r_vec_len == LAST_IDX));
        w_release   = (r_state == HOLD) && vec_ready;
        w_state_nxt = r_state;
        if (sync_clr) begin
            w_state_nxt = FILL;
        end else if (w_final) begin
            w_state_nxt = HOLD;
        end else if (w_release) begin
            w_state_nxt = FILL;
        end
    end

    // ---- byte insertion at the current fill position ----
    always_comb begin
        w_bit_base = {r_vec_len[4:0], 3'b000};
        w_vec_ins  = {1'b0, r_vec};
        w_vec_ins[w_bit_base +: 8] = in_data;
    end

    // ---- datapath: vector, length and frame counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= '0;
            r_vec_len   <= '0;
            r_frame_cnt <= '0;
        end else if (sync_clr) begin
            // Discard wins over both accept and release; frame not counted.
            r_vec     <= '0;
            r_vec_len <= '0;
        end else if (w_release) begin
            r_vec       <= '0;
            r_vec_len   <= '0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end else if (w_accept) begin
            r_vec     <= w_vec_ins[VEC_W-1:0];
            r_vec_len <= r_vec_len + LEN_W'(1);
        end
    end

    assign in_ready  = (r_state == FILL);
    assign vec_valid = (r_state == HOLD);
    assign vec       = r_vec;
    assign vec_len   = r_vec_len;
    assign frame_cnt = r_frame_cnt;

endmodule : vector_assembler

// File: tb/tb_vector_assembler.sv
module tb_vector_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         sync_clr;
    logic [254:0] vec;
    logic         vec_valid;
    logic         vec_ready;
    logic [5:0]   vec_len;
    logic [7:0]   frame_cnt;

    int n_vec;
    int n_bad;

    vector_assembler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sync_clr  (sync_clr),
        .vec       (vec),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_len   (vec_len),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: frame as a list of bytes ----------------
    logic [7:0] m_q[$];
    logic       m_held;
    int         m_cnt;

    function automatic logic [254:0] model_vec();
        logic [255:0] acc;
        acc = '0;
        for (int i = 0; i < m_q.size(); i++)
            acc = acc | (256'(m_q[i]) << (8 * i));
        return acc[254:0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_held = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic v, l, c, r);
        if (c) begin
            m_q.delete();
            m_held = 1'b0;
        end else if (m_held) begin
            if (r) begin
                m_held = 1'b0;
                m_q.delete();
                m_cnt  = (m_cnt + 1) % 256;
            end
        end else if (v) begin
            m_q.push_back(d);
            if (l || m_q.size() == 32) m_held = 1'b1;
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " vec"},       vec,                 model_vec());
        chk({tag, " vec_len"},   255'(vec_len),       255'(m_q.size()));
        chk({tag, " vec_valid"}, 255'(vec_valid),     255'(m_held));
        chk({tag, " in_ready"},  255'(in_ready),      255'(!m_held));
        chk({tag, " frame_cnt"}, 255'(frame_cnt),     255'(m_cnt));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " vec"},       vec,             '0);
        chk({tag, " vec_len"},   255'(vec_len),   '0);
        chk({tag, " vec_valid"}, 255'(vec_valid), '0);
        chk({tag, " in_ready"},  255'(in_ready),  255'(1));
        chk({tag, " frame_cnt"}, 255'(frame_cnt), '0);
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample at edge+1.
    task automatic cycle(input logic [7:0] d, input logic v, l, c, r);
        in_data   = d;
        in_valid  = v;
        in_last   = l;
        sync_clr  = c;
        vec_ready = r;
        @(posedge clk);
        model_step(d, v, l, c, r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; sync_clr = 1'b0; vec_ready = 1'b0; in_data = 8'h00;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  d;
        logic        v, l, c, r;
        logic        e_rdy, e_vld;
        logic [5:0]  e_len;
        logic [15:0] e_vec;
        logic [7:0]  e_cnt;
    } tvec_t;

    tvec_t tbl[13];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; sync_clr = 1'b0; vec_ready = 1'b0;
        model_reset();

        //         d      v     l     c     r     rdy   vld   len    vec16     cnt
        tbl[0]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 16'h0001, 8'd0};
        tbl[1]  = '{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0201, 8'd0};
        tbl[2]  = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0201, 8'd0};
        tbl[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0201, 8'd0};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0201, 8'd0};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0201, 8'd0};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0201, 8'd0};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0000, 8'd1};
        tbl[8]  = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0000, 8'd1};
        tbl[9]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 16'h0033, 8'd1};
        tbl[10] = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'h0000, 8'd1};
        tbl[11] = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 16'h0077, 8'd1};
        tbl[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0000, 8'd1};

        // Reset values before any edge completes the reset.
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // 32 x 0xFF back-to-back, vec_ready held high throughout.
        for (int i = 0; i < 32; i++) cycle(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("ones vec", vec, {255{1'b1}});
        chk("ones len", 255'(vec_len), 255'(32));
        chk("ones vld", 255'(vec_valid), 255'(1));
        check_model("ones");
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ones vld drop", 255'(vec_valid), '0);
        chk("ones cnt", 255'(frame_cnt), 255'(1));

        // Directed table from a clean reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d rdy", i), 255'(in_ready),  255'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d vld", i), 255'(vec_valid), 255'(tbl[i].e_vld));
            chk($sformatf("tbl%0d len", i), 255'(vec_len),   255'(tbl[i].e_len));
            chk($sformatf("tbl%0d vec", i), vec,             255'(tbl[i].e_vec));
            chk($sformatf("tbl%0d cnt", i), 255'(frame_cnt), 255'(tbl[i].e_cnt));
        end

        // Byte 31 = 0x80, all others zero: its bit lands outside the vector.
        for (int i = 0; i < 31; i++) cycle(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("msb drop vec", vec, '0);
        chk("msb drop len", 255'(vec_len), 255'(32));
        chk("msb drop vld", 255'(vec_valid), 255'(1));
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_model("msb drop rel");

        // 10 bytes, then sync_clr with a valid byte; next frame starts at index 0.
        for (int i = 0; i < 10; i++) cycle(8'(i + 8'h10), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr vec", vec, '0);
        chk("clr len", 255'(vec_len), '0);
        chk("clr cnt", 255'(frame_cnt), 255'(2));
        cycle(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr next vec", vec, 255'(8'h5A));
        check_model("clr next");

        // Asynchronous reset while in HOLD, between clock edges.
        cycle(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("hold before rst", 255'(vec_valid), 255'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async rst");
        model_reset();
        #2;
        rst_n = 1'b1;

        // 257 single-byte frames, each with exactly one HOLD cycle.
        for (int f = 0; f < 257; f++) begin
            cycle(8'(f), 1'b1, 1'b1, 1'b0, 1'b0);
            if (f % 64 == 0) check_model("wrap acc");
            cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("wrap cnt", 255'(frame_cnt), 255'(1));
        check_model("wrap end");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(8'($urandom),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 1) == 1));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_vector_assembler
